// File: rtl/pb_gpio_multi_pkg.sv
// pb_gpio_multi_pkg: shared register offsets, bank stride and channel limit for the multi-bank PicoBlaze GPIO
package pb_gpio_multi_pkg;
  localparam int CHANNEL_STRIDE = 8;
  localparam int MAX_CHANNELS = 4;
  typedef enum logic [2:0] {
    REG_DATA       = 3'd0,
    REG_DIR        = 3'd1,
    REG_IRQ_MASK   = 3'd2,
    REG_IRQ_STATUS = 3'd3,
    REG_EDGE_POL   = 3'd4,
    REG_EDGE_BOTH  = 3'd5
  } reg_e;
endpackage

// File: rtl/pb_gpio_multi_channel.sv
// pb_gpio_multi_channel: one 8-bit bank (regs, 2-flop sync, optional PB_GPIO_DEBOUNCE_EN filter, edge irq, tristate pins); ports clk/reset, sel/we/addr/wdata bus slice, armed, rdata/irq out, pins inout
module pb_gpio_multi_channel
  import pb_gpio_multi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  input  logic       armed,
  output logic [7:0] rdata,
  output logic       irq,
  inout  wire  [7:0] pins
);
  logic [7:0] data_q, data_d, dir_q, dir_d, mask_q, mask_d, status_q, status_d;
  logic [7:0] pol_q, pol_d, both_q, both_d, sync1_q, sync2_q, prev_q, s, ev, clr;
  logic       wr;
  assign wr = sel & we;
  always_comb begin
    clr      = (wr && addr == REG_IRQ_STATUS) ? wdata : 8'h00;
    ev       = {8{armed}} & ((s & ~prev_q & (both_q | ~pol_q)) | (~s & prev_q & (both_q | pol_q)));
    data_d   = (wr && addr == REG_DATA) ? wdata : data_q;
    dir_d    = (wr && addr == REG_DIR) ? wdata : dir_q;
    mask_d   = (wr && addr == REG_IRQ_MASK) ? wdata : mask_q;
    pol_d    = (wr && addr == REG_EDGE_POL) ? wdata : pol_q;
    both_d   = (wr && addr == REG_EDGE_BOTH) ? wdata : both_q;
    status_d = (status_q & ~clr) | ev;
    rdata    = !sel ? 8'h00 :
               addr == REG_DATA       ? s :
               addr == REG_DIR        ? dir_q :
               addr == REG_IRQ_MASK   ? mask_q :
               addr == REG_IRQ_STATUS ? status_q :
               addr == REG_EDGE_POL   ? pol_q :
               addr == REG_EDGE_BOTH  ? both_q : 8'h00;
    irq      = |(status_q & mask_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      dir_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
      pol_q    <= '0;
      both_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
    end else begin
      data_q   <= data_d;
      dir_q    <= dir_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      pol_q    <= pol_d;
      both_q   <= both_d;
      sync1_q  <= pins;
      sync2_q  <= sync1_q;
      prev_q   <= s;
    end
  end
`ifdef PB_GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [7:0][CW-1:0] cnt_q, cnt_d;
  logic [7:0]         s_q, s_d;
  always_comb begin
    cnt_d = cnt_q;
    s_d   = s_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = (sync2_q[i] == s_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      s_d[i]   = (sync2_q[i] != s_q[i] && cnt_q[i] == LAST) ? sync2_q[i] : s_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      s_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      s_q   <= s_d;
    end
  end
  assign s = s_q;
`else
  assign s = sync2_q;
`endif
  for (genvar b = 0; b < 8; b++) begin : g_pin
    assign pins[b] = dir_q[b] ? data_q[b] : 1'bz;
  end
endmodule

// File: rtl/pb_gpio_multi.sv
// pb_gpio_multi: NUM_CHANNELS x 8-bit KCPSM6 GPIO banks (opt. PB_GPIO_DEBOUNCE_EN); ports clk, reset, port_id, data_in, write_strobe, read_strobe, data_out (0 unless addressed), interrupt, gpio inout
module pb_gpio_multi
  import pb_gpio_multi_pkg::*;
#(
  parameter int GPIO_BASE_ADDRESS = 0,
  parameter int NUM_CHANNELS      = 2,
  parameter int DEBOUNCE_CYCLES   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                port_id,
  input  logic [7:0]                data_in,
  input  logic                      write_strobe,
  input  logic                      read_strobe,
  output logic [7:0]                data_out,
  output logic                      interrupt,
  inout  wire  [8*NUM_CHANNELS-1:0] gpio
);
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS) begin : g_bad_n
    $error("NUM_CHANNELS out of range");
  end
  if (GPIO_BASE_ADDRESS % CHANNEL_STRIDE != 0) begin : g_bad_base
    $error("GPIO_BASE_ADDRESS not aligned");
  end
  logic [7:0] rd_c [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] irq_c;
  logic [7:0] off, data_out_q, data_out_d;
  logic [1:0] ch, arm_q, arm_d;
  logic       hit, armed, interrupt_q, interrupt_d, unused_ok;
  assign hit       = int'(port_id) >= GPIO_BASE_ADDRESS &&
                     int'(port_id) < GPIO_BASE_ADDRESS + CHANNEL_STRIDE * NUM_CHANNELS;
  assign off       = port_id - 8'(GPIO_BASE_ADDRESS);
  assign ch        = off[4:3];
  assign armed     = arm_q == 2'd3;
  assign unused_ok = ^{read_strobe, off[7:5]};
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    pb_gpio_multi_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk   (clk),
      .reset (reset),
      .sel   (hit && ch == 2'(c)),
      .we    (write_strobe),
      .addr  (off[2:0]),
      .wdata (data_in),
      .armed (armed),
      .rdata (rd_c[c]),
      .irq   (irq_c[c]),
      .pins  (gpio[CHANNEL_STRIDE*c +: 8])
    );
  end
  always_comb begin
    data_out_d = 8'h00;
    for (int i = 0; i < NUM_CHANNELS; i++) data_out_d = data_out_d | rd_c[i];
    interrupt_d = |irq_c;
    arm_d       = armed ? arm_q : arm_q + 2'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= '0;
      interrupt_q <= 1'b0;
      arm_q       <= '0;
    end else begin
      data_out_q  <= data_out_d;
      interrupt_q <= interrupt_d;
      arm_q       <= arm_d;
    end
  end
  assign data_out  = data_out_q;
  assign interrupt = interrupt_q;
endmodule

// File: tb/tb_pb_gpio_multi.sv
// tb_pb_gpio_multi: scoreboard bench for pb_gpio_multi with base 0x10 and two banks
module tb_pb_gpio_multi;
  localparam int DEB = 4;
`ifdef PB_GPIO_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset, write_strobe, read_strobe;
  logic [7:0]  port_id, data_in, tb_pins;
  wire  [7:0]  data_out;
  wire         interrupt;
  wire  [15:0] gpio;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  assign gpio[7:0] = tb_pins;
  always #5 clk = ~clk;
  pb_gpio_multi #(.GPIO_BASE_ADDRESS(16), .NUM_CHANNELS(2), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .data_in      (data_in),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .data_out     (data_out),
    .interrupt    (interrupt),
    .gpio         (gpio)
  );
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a;
    data_in = d;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask
  task automatic rd(input string n, input logic [7:0] a, input logic [7:0] e);
    q.push_back('{name: n, exp: e});
    port_id = a;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
  endtask
  always begin
    exp_t e;
    @(posedge clk);
    if (read_strobe) begin
      #1;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: got %h want nothing", data_out);
      end else begin
        e = q.pop_front();
        if (data_out !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, data_out, e.exp);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    port_id = 8'h00;
    data_in = 8'h00;
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    tb_pins = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_irq", {7'd0, interrupt}, 8'h00);
    chk("reset_dout", data_out, 8'h00);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    for (int a = 16; a < 32; a++) rd($sformatf("reset_rd_%0h", a), 8'(a), 8'h00);
    chk("reset_irq2", {7'd0, interrupt}, 8'h00);
    wr(8'h19, 8'hFF);
    wr(8'h18, 8'hA5);
    chk("pins_ch1", gpio[15:8], 8'hA5);
    repeat (LAT) @(negedge clk);
    rd("data_ch1", 8'h18, 8'hA5);
    rd("dir_ch1", 8'h19, 8'hFF);
    rd("out_of_window", 8'h30, 8'h00);
    wr(8'h12, 8'h01);
    wr(8'h14, 8'h00);
    tb_pins[0] = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("irq_not_yet", {7'd0, interrupt}, 8'h00);
    @(negedge clk);
    chk("irq_rise", {7'd0, interrupt}, 8'h01);
    rd("status_rise", 8'h13, 8'h01);
    wr(8'h13, 8'h01);
    @(negedge clk);
    chk("irq_w1c", {7'd0, interrupt}, 8'h00);
    tb_pins[0] = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    rd("status_fall", 8'h13, 8'h00);
    chk("irq_fall", {7'd0, interrupt}, 8'h00);
    wr(8'h15, 8'h80);
    wr(8'h12, 8'h80);
    tb_pins[7] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    rd("status_both1", 8'h13, 8'h80);
    chk("irq_both1", {7'd0, interrupt}, 8'h01);
    tb_pins[7] = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    wr(8'h13, 8'h80);
    repeat (2) @(negedge clk);
    rd("status_set_wins", 8'h13, 8'h80);
    wr(8'h12, 8'h00);
    @(negedge clk);
    chk("irq_masked", {7'd0, interrupt}, 8'h00);
    rd("status_kept", 8'h13, 8'h80);
    wr(8'h13, 8'h80);
    rd("status_cleared", 8'h13, 8'h00);
`ifdef PB_GPIO_DEBOUNCE_EN
    wr(8'h15, 8'h00);
    wr(8'h12, 8'h04);
    tb_pins[2] = 1'b1;
    repeat (3) @(negedge clk);
    tb_pins[2] = 1'b0;
    repeat (12) @(negedge clk);
    rd("glitch_status", 8'h13, 8'h00);
    rd("glitch_data", 8'h10, 8'h00);
    tb_pins[2] = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("deb_irq_not_yet", {7'd0, interrupt}, 8'h00);
    @(negedge clk);
    chk("deb_irq", {7'd0, interrupt}, 8'h01);
    repeat (2) @(negedge clk);
    tb_pins[2] = 1'b0;
    rd("deb_status", 8'h13, 8'h04);
`else
    tb_pins = 8'hFF;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    rd("arm_status", 8'h13, 8'h00);
    chk("arm_irq", {7'd0, interrupt}, 8'h00);
    rd("arm_data", 8'h10, 8'hFF);
    rd("arm_mask", 8'h12, 8'h00);
    rd("arm_dir_ch1", 8'h19, 8'h00);
`endif
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
